// File: rtl/usb_crc_pkg.sv
// usb_crc_pkg: shared constants, FSM state type and CRC5 helper functions
// for the USB token CRC5 controller.
//   CRC5_POLY / CRC5_INIT / CRC5_RESIDUAL : USB CRC5 (x^5+x^2+1) constants
//   crc5_state_t                          : controller FSM states
//   crc5_step()                           : one serial LFSR step
//   crc5_wire()                           : final LFSR -> 5 transmitted CRC bits
package usb_crc_pkg;

  localparam int unsigned CRC_W  = 5;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 5;

  localparam logic [CRC_W-1:0] CRC5_POLY     = 5'b00101;
  localparam logic [CRC_W-1:0] CRC5_INIT     = 5'b11111;
  localparam logic [CRC_W-1:0] CRC5_RESIDUAL = 5'b01100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } crc5_state_t;

  // One bit of the serial CRC: feedback is the incoming bit xor the LFSR MSB.
  function automatic logic [CRC_W-1:0] crc5_step(input logic [CRC_W-1:0] lfsr,
                                                 input logic             din);
    logic fb;
    fb = din ^ lfsr[CRC_W-1];
    return {lfsr[CRC_W-2:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
  endfunction

  // Inverted CRC, reordered so bit 0 is the first CRC bit on the wire (LFSR MSB).
  function automatic logic [CRC_W-1:0] crc5_wire(input logic [CRC_W-1:0] lfsr);
    return ~{lfsr[0], lfsr[1], lfsr[2], lfsr[3], lfsr[4]};
  endfunction

endpackage

// File: rtl/usb_crc5_ctrl_if.sv
// usb_crc5_ctrl_if: request/response handshake bundle of the CRC5 controller.
//   req_valid/req_ready/req_data : token field request (master -> slave)
//   rsp_valid/rsp_ready/rsp_data : token body with CRC5 (slave -> master)
//   chk_mode/crc_err             : present only with USB_CRC5_CHECK_EN defined
// modport master = token builder side, modport slave = controller side.
interface usb_crc5_ctrl_if;

  logic                            req_valid;
  logic                            req_ready;
  logic [usb_crc_pkg::DATA_W-1:0]  req_data;
  logic                            rsp_valid;
  logic                            rsp_ready;
  logic [usb_crc_pkg::DATA_W-1:0]  rsp_data;
`ifdef USB_CRC5_CHECK_EN
  logic                            chk_mode;
  logic                            crc_err;

  modport master (output req_valid, req_data, rsp_ready, chk_mode,
                  input  req_ready, rsp_valid, rsp_data, crc_err);
  modport slave  (input  req_valid, req_data, rsp_ready, chk_mode,
                  output req_ready, rsp_valid, rsp_data, crc_err);
`else
  modport master (output req_valid, req_data, rsp_ready,
                  input  req_ready, rsp_valid, rsp_data);
  modport slave  (input  req_valid, req_data, rsp_ready,
                  output req_ready, rsp_valid, rsp_data);
`endif

endinterface

// File: rtl/crc5_serial.sv
// crc5_serial: bit-serial USB CRC5 LFSR.
//   clk, rst  : clock, synchronous active-high reset (LFSR -> CRC5_INIT)
//   init      : reload LFSR with CRC5_INIT
//   shift_en  : advance LFSR by one input bit
//   din       : serial data bit
//   crc[4:0]  : current LFSR contents
module crc5_serial
  import usb_crc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             shift_en,
  input  logic             din,
  output logic [CRC_W-1:0] crc
);

  always_ff @(posedge clk) begin
    if (rst || init) begin
      crc <= CRC5_INIT;
    end else if (shift_en) begin
      crc <= crc5_step(crc, din);
    end
  end

endmodule

// File: rtl/usb_crc5_ctrl.sv
// usb_crc5_ctrl: sequences a bit-serial CRC5 over an 11-bit USB token field
// and returns {crc5, field}. Optional check mode (macro USB_CRC5_CHECK_EN)
// shifts a full received 16-bit token and flags a bad residual.
//   clk, rst : clock, synchronous active-high reset
//   bus      : usb_crc5_ctrl_if.slave (req_*/rsp_*, plus chk_mode/crc_err
//              when USB_CRC5_CHECK_EN is defined)
//   FIELD_W  : token field width (11 for USB traffic)
module usb_crc5_ctrl
  import usb_crc_pkg::*;
#(
  parameter int unsigned FIELD_W = 11
) (
  input  logic           clk,
  input  logic           rst,
  usb_crc5_ctrl_if.slave bus
);

  localparam int unsigned       CRC_LSB    = 11;
  localparam logic [DATA_W-1:0] FIELD_MASK = DATA_W'((64'd1 << FIELD_W) - 64'd1);

  crc5_state_t       state, state_next;
  logic [DATA_W-1:0] data_q, sreg;
  logic [CNT_W-1:0]  cnt;
  logic              chk_q, chk_req, accept, shifting;
  logic [CRC_W-1:0]  crc, crc_fin;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

`ifdef USB_CRC5_CHECK_EN
  logic crc_err_q, crc_err_d;
  assign chk_req = bus.chk_mode;
`else
  assign chk_req = 1'b0;
`endif

  assign accept   = (state == IDLE) && bus.req_valid && req_ready_q;
  assign shifting = (state == SHIFT);
  // LFSR value after the bit being shifted this cycle; used on the last bit.
  assign crc_fin  = crc5_step(crc, sreg[0]);

  crc5_serial u_crc (
    .clk      (clk),
    .rst      (rst),
    .init     (accept),
    .shift_en (shifting),
    .din      (sreg[0]),
    .crc      (crc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) state_next = DONE;
      DONE:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    req_ready_d = (state_next == IDLE);
    rsp_valid_d = (state_next == DONE);
    rsp_data_d  = rsp_data_q;
`ifdef USB_CRC5_CHECK_EN
    crc_err_d   = crc_err_q;
`endif
    if (shifting && (state_next == DONE)) begin
      if (chk_q) rsp_data_d = data_q;
      else       rsp_data_d = (data_q & FIELD_MASK) | (DATA_W'(crc5_wire(crc_fin)) << CRC_LSB);
`ifdef USB_CRC5_CHECK_EN
      crc_err_d = chk_q && (crc_fin != CRC5_RESIDUAL);
`endif
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef USB_CRC5_CHECK_EN
      crc_err_q   <= 1'b0;
`endif
    end else begin
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef USB_CRC5_CHECK_EN
      crc_err_q   <= crc_err_d;
`endif
    end
  end

  // Request capture, serial shift register and bit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      sreg   <= '0;
      cnt    <= '0;
      chk_q  <= 1'b0;
    end else if (accept) begin
      data_q <= bus.req_data;
      sreg   <= bus.req_data;
      cnt    <= chk_req ? CNT_W'(DATA_W) : CNT_W'(FIELD_W);
      chk_q  <= chk_req;
    end else if (shifting) begin
      sreg   <= {1'b0, sreg[DATA_W-1:1]};
      cnt    <= cnt - CNT_W'(1);
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
`ifdef USB_CRC5_CHECK_EN
  assign bus.crc_err   = crc_err_q;
`endif

endmodule

// File: tb/tb_usb_crc5_ctrl.sv
// tb_usb_crc5_ctrl: self-checking bench for usb_crc5_ctrl (FIELD_W = 11).
// Reference CRC uses the reflected USB CRC5 formulation (poly 0x14, init 0x1F,
// inverted result, LSB first). Check-mode cases build with USB_CRC5_CHECK_EN.
module tb_usb_crc5_ctrl;

  typedef struct {
    logic [15:0] din;
    logic        chk;
    logic [15:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic acc_seen;

  usb_crc5_ctrl_if bus();

  usb_crc5_ctrl #(.FIELD_W(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] ref_crc(input logic [10:0] f);
    logic [4:0] r;
    r = 5'h1f;
    for (int i = 0; i < 11; i++) begin
      if (r[0] ^ f[i]) r = (r >> 1) ^ 5'h14;
      else             r = r >> 1;
    end
    return ~r;
  endfunction

  function automatic logic [15:0] gen_tok(input logic [10:0] f);
    return {ref_crc(f), f};
  endfunction

  function automatic logic tok_bad(input logic [15:0] t);
    return ref_crc(t[10:0]) != t[15:11];
  endfunction

  function automatic vec_t mk_vec(input logic [15:0] d, input logic cm);
    vec_t v;
    v.din      = d;
    v.chk      = cm;
    v.exp_data = cm ? d : gen_tok(d[10:0]);
    v.exp_err  = cm ? tok_bad(d) : 1'b0;
    v.exp_lat  = cm ? 17 : 12;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; acc_seen reports whether a request was taken on that edge.
  task automatic tick();
    acc_seen = bus.req_valid && bus.req_ready && !rst;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One full transaction with rsp_ready withheld for 'hold' cycles.
  task automatic do_txn(input vec_t v, input int hold, input string tag);
    int          n;
    logic        ok;
    logic [15:0] snap;
    n = 0;
    while (!bus.req_ready && n < 50) begin tick(); n++; end
    chk({tag, " ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_data  = v.din;
`ifdef USB_CRC5_CHECK_EN
    bus.chk_mode  = v.chk;
`endif
    tick();
    chk({tag, " accept"}, 32'(acc_seen), 32'd1);
    bus.req_valid = 1'b0;
    bus.req_data  = 16'($urandom);
    n  = 1;
    ok = 1'b1;
    while (!bus.rsp_valid && n < 40) begin
      if (bus.req_ready) ok = 1'b0;
      tick();
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(v.exp_lat));
    chk({tag, " busy"}, 32'(ok), 32'd1);
    chk({tag, " data"}, 32'(bus.rsp_data), 32'(v.exp_data));
`ifdef USB_CRC5_CHECK_EN
    chk({tag, " crc_err"}, 32'(bus.crc_err), 32'(v.exp_err));
`endif
    snap = bus.rsp_data;
    ok   = 1'b1;
    for (int i = 0; i < hold; i++) begin
      bus.rsp_ready = 1'b0;
      tick();
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== snap || bus.req_ready !== 1'b0) ok = 1'b0;
`ifdef USB_CRC5_CHECK_EN
      if (bus.crc_err !== v.exp_err) ok = 1'b0;
`endif
    end
    if (hold > 0) chk({tag, " stable"}, 32'(ok), 32'd1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk({tag, " release"}, {30'd0, bus.rsp_valid, bus.req_ready}, 32'd1);
  endtask

  initial begin
    vec_t        vecs[$];
    vec_t        v;
    int          n, sent, recv;
    logic        ok, took;
    logic [15:0] got, cur_d;
    logic [15:0] expq[$];
    int          acc_cyc[$];

    rst           = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_data  = 16'h0000;
    bus.rsp_ready = 1'b0;
`ifdef USB_CRC5_CHECK_EN
    bus.chk_mode  = 1'b0;
`endif

    // Reset held with a pending request
    ok = 1'b1;
    repeat (3) begin
      tick();
      if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 16'h0000 || bus.req_ready !== 1'b0) ok = 1'b0;
    end
    chk("reset outputs", 32'(ok), 32'd1);
    bus.req_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("ready after reset", 32'(bus.req_ready), 32'd1);
    chk("no rsp after reset", 32'(bus.rsp_valid), 32'd0);

    // Directed vector table
    vecs.push_back('{16'h0000, 1'b0, 16'h1000, 1'b0, 12});
    vecs.push_back('{16'hF800, 1'b0, 16'h1000, 1'b0, 12});
    vecs.push_back(mk_vec(16'h07FF, 1'b0));
    vecs.push_back(mk_vec(16'h0123, 1'b0));
    vecs.push_back(mk_vec(16'h0400, 1'b0));
`ifdef USB_CRC5_CHECK_EN
    vecs.push_back('{16'h1000, 1'b1, 16'h1000, 1'b0, 17});
    vecs.push_back('{16'h1001, 1'b1, 16'h1001, 1'b1, 17});
    vecs.push_back(mk_vec(gen_tok(11'h3A5), 1'b1));
    vecs.push_back(mk_vec(gen_tok(11'h3A5) ^ 16'h0800, 1'b1));
`endif
    foreach (vecs[i]) do_txn(vecs[i], 2, $sformatf("vec%0d", i));

    // Random fields with backpressure
    for (int i = 0; i < 10; i++) begin
      v = mk_vec(16'($urandom), 1'b0);
      do_txn(v, 5, $sformatf("rnd%0d", i));
    end
`ifdef USB_CRC5_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      cur_d = gen_tok(11'($urandom));
      if (i[0]) cur_d = cur_d ^ (16'd1 << $urandom_range(15, 0));
      v = mk_vec(cur_d, 1'b1);
      do_txn(v, 1, $sformatf("chk%0d", i));
    end
    bus.chk_mode = 1'b0;
`endif

    // Back-to-back with req_valid and rsp_ready held high
    sent  = 0;
    recv  = 0;
    n     = 0;
    cur_d = 16'($urandom);
    bus.req_data  = cur_d;
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    while ((sent < 4 || recv < 4) && n < 200) begin
      took = bus.rsp_valid && bus.rsp_ready;
      got  = bus.rsp_data;
      tick();
      n++;
      if (acc_seen) begin
        acc_cyc.push_back(cyc);
        expq.push_back(gen_tok(cur_d[10:0]));
        sent++;
        if (sent < 4) begin
          cur_d = 16'($urandom);
          bus.req_data = cur_d;
        end else begin
          bus.req_valid = 1'b0;
        end
      end
      if (took && expq.size() > 0) begin
        chk($sformatf("b2b rsp%0d", recv), 32'(got), 32'(expq.pop_front()));
        recv++;
      end
    end
    bus.rsp_ready = 1'b0;
    chk("b2b accepts", 32'(sent), 32'd4);
    chk("b2b responses", 32'(recv), 32'd4);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk($sformatf("b2b spacing%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd13);

    // Reset in the middle of SHIFT drops the transaction
    n = 0;
    while (!bus.req_ready && n < 50) begin tick(); n++; end
    bus.req_valid = 1'b1;
    bus.req_data  = 16'h0555;
    tick();
    chk("midrst accept", 32'(acc_seen), 32'd1);
    bus.req_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ok = 1'b1;
    repeat (20) begin
      tick();
      if (bus.rsp_valid !== 1'b0) ok = 1'b0;
    end
    chk("midrst no rsp", 32'(ok), 32'd1);
    chk("midrst data cleared", 32'(bus.rsp_data), 32'd0);
    do_txn('{16'h0000, 1'b0, 16'h1000, 1'b0, 12}, 0, "after midrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
